// File: rtl/sg_pkg.sv
// Shared types and constants for the signal-generator sweep sequencer.
package sg_pkg;

   localparam int FREQ_CODE_W = 3;
   localparam int PER_CODE_W  = 3;
   localparam int DUTY_CODE_W = 2;

   // Longest generator output period in clocks; one full period is the settle default.
   localparam int GEN_PERIOD_MAX = 2**18;

   typedef logic [FREQ_CODE_W-1:0] freqCode_t;
   typedef logic [PER_CODE_W-1:0]  perCode_t;
   typedef logic [DUTY_CODE_W-1:0] dutyCode_t;

   localparam dutyCode_t DUTY_LAST = '1;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      MEASURE,
      ADVANCE
   } sgState_t;

endpackage

// File: rtl/sg_code_stepper.sv
// Nested duty/period/frequency code counter; duty is innermost, frequency outermost.
module sg_code_stepper
   import sg_pkg::*;
#(
   parameter int F_MIN = 1,
   parameter int F_MAX = 7,
   parameter int P_MIN = 1,
   parameter int P_MAX = 7
) (
   input  logic      Clk,
   input  logic      Rst_n,
   input  logic      Clear,
   input  logic      Load,
   input  logic      Step,
   output freqCode_t Freq,
   output perCode_t  Per,
   output dutyCode_t Duty,
   output logic      FinalWrap
);

   localparam freqCode_t F_FIRST = freqCode_t'(F_MIN);
   localparam freqCode_t F_LAST  = freqCode_t'(F_MAX);
   localparam perCode_t  P_FIRST = perCode_t'(P_MIN);
   localparam perCode_t  P_LAST  = perCode_t'(P_MAX);

   // High while the codes sit on the last sweep point, so the next Step wraps all three.
   assign FinalWrap = (Duty == DUTY_LAST) && (Per == P_LAST) && (Freq == F_LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Freq <= '0;
         Per  <= '0;
         Duty <= '0;
      end else if (Clear) begin
         Freq <= '0;
         Per  <= '0;
         Duty <= '0;
      end else if (Load) begin
         Freq <= F_FIRST;
         Per  <= P_FIRST;
         Duty <= '0;
      end else if (Step) begin
         if (Duty == DUTY_LAST) begin
            Duty <= '0;
            if (Per == P_LAST) begin
               Per  <= P_FIRST;
               Freq <= (Freq == F_LAST) ? F_FIRST : Freq + 1'b1;
            end else begin
               Per <= Per + 1'b1;
            end
         end else begin
            Duty <= Duty + 1'b1;
         end
      end
   end

endmodule

// File: rtl/siggen_sweep_controller.sv
// Sweeps the generator codes, settling and requesting one meter measurement per point.
//
//   state   | meaning
//   IDLE    | waiting for Start; codes hold last point (or 0 after reset/abort)
//   SETTLE  | new codes applied, counting settle time
//   MEASURE | MeasStart issued, waiting for MeasDone or timeout
//   ADVANCE | one cycle: step codes and StepIndex, decide wrap/finish
module siggen_sweep_controller
   import sg_pkg::*;
#(
   parameter int F_MIN          = 1,
   parameter int F_MAX          = 7,
   parameter int P_MIN          = 1,
   parameter int P_MAX          = 7,
   parameter int SETTLE_CYCLES  = GEN_PERIOD_MAX,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int CNT_W          = 21
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   Start,
   input  logic                   Abort,
   input  logic                   Continuous,
   input  logic                   MeasDone,
   output logic [FREQ_CODE_W-1:0] ControlFrequency,
   output logic [PER_CODE_W-1:0]  ControlPeriodic,
   output logic [DUTY_CODE_W-1:0] ControlDuty,
   output logic                   MeasStart,
   output logic                   Busy,
   output logic                   SweepDone,
   output logic [7:0]             StepIndex,
   output logic                   ErrTimeout
);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   sgState_t         state;
   logic [CNT_W-1:0] cnt;
   logic             contLatched;
   logic             stepClear;
   logic             stepLoad;
   logic             stepAdv;
   logic             finalWrap;

   // A non-continuous sweep must not step past its last point so the codes stay there.
   always_comb begin
      stepClear = 1'b0;
      stepLoad  = 1'b0;
      stepAdv   = 1'b0;
      if (Abort) begin
         stepClear = 1'b1;
      end else begin
         case (state)
            IDLE:    stepLoad = Start;
            ADVANCE: stepAdv  = !finalWrap || contLatched;
            default: ;
         endcase
      end
   end

   sg_code_stepper #(
      .F_MIN(F_MIN),
      .F_MAX(F_MAX),
      .P_MIN(P_MIN),
      .P_MAX(P_MAX)
   ) u_stepper (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Clear    (stepClear),
      .Load     (stepLoad),
      .Step     (stepAdv),
      .Freq     (ControlFrequency),
      .Per      (ControlPeriodic),
      .Duty     (ControlDuty),
      .FinalWrap(finalWrap)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         contLatched <= 1'b0;
         MeasStart   <= 1'b0;
         Busy        <= 1'b0;
         SweepDone   <= 1'b0;
         StepIndex   <= '0;
         ErrTimeout  <= 1'b0;
      end else begin
         MeasStart <= 1'b0;
         SweepDone <= 1'b0;
         if (Abort) begin
            state <= IDLE;
            cnt   <= '0;
            Busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (Start) begin
                     contLatched <= Continuous;
                     ErrTimeout  <= 1'b0;
                     StepIndex   <= '0;
                     cnt         <= '0;
                     Busy        <= 1'b1;
                     state       <= SETTLE;
                  end
               end
               SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt       <= '0;
                     MeasStart <= 1'b1;
                     state     <= MEASURE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               MEASURE: begin
                  cnt <= cnt + 1'b1;
                  // A done arriving on the timeout cycle still counts as a good measurement.
                  if (MeasDone) begin
                     state <= ADVANCE;
                  end else if (cnt == TIMEOUT_LAST) begin
                     ErrTimeout <= 1'b1;
                     state      <= ADVANCE;
                  end
               end
               ADVANCE: begin
                  cnt <= '0;
                  if (finalWrap && contLatched) begin
                     StepIndex <= '0;
                     state     <= SETTLE;
                  end else if (finalWrap) begin
                     StepIndex <= StepIndex + 1'b1;
                     SweepDone <= 1'b1;
                     Busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     StepIndex <= StepIndex + 1'b1;
                     state     <= SETTLE;
                  end
               end
               default: begin
                  Busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_siggen_sweep_controller.sv
// Directed bench for siggen_sweep_controller with a small 2x2x4 sweep.
module tb_siggen_sweep_controller;

   logic       Clk;
   logic       Rst_n;
   logic       Start;
   logic       Abort;
   logic       Continuous;
   logic       MeasDone;
   logic [2:0] ControlFrequency;
   logic [2:0] ControlPeriodic;
   logic [1:0] ControlDuty;
   logic       MeasStart;
   logic       Busy;
   logic       SweepDone;
   logic [7:0] StepIndex;
   logic       ErrTimeout;

   logic meterDone;
   logic manualDone;
   logic meterMode;

   int nChecks = 0;
   int nFails  = 0;

   assign MeasDone = meterDone | manualDone;

   siggen_sweep_controller #(
      .F_MIN(6),
      .F_MAX(7),
      .P_MIN(6),
      .P_MAX(7),
      .SETTLE_CYCLES(4),
      .TIMEOUT_CYCLES(16),
      .CNT_W(21)
   ) dut (
      .Clk             (Clk),
      .Rst_n           (Rst_n),
      .Start           (Start),
      .Abort           (Abort),
      .Continuous      (Continuous),
      .MeasDone        (MeasDone),
      .ControlFrequency(ControlFrequency),
      .ControlPeriodic (ControlPeriodic),
      .ControlDuty     (ControlDuty),
      .MeasStart       (MeasStart),
      .Busy            (Busy),
      .SweepDone       (SweepDone),
      .StepIndex       (StepIndex),
      .ErrTimeout      (ErrTimeout)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Meter model: answers each MeasStart with a done pulse sampled two edges later.
   initial begin
      meterDone = 1'b0;
      forever begin
         @(negedge Clk);
         if (meterMode && MeasStart) begin
            @(posedge Clk);
            #1 meterDone = 1'b1;
            @(posedge Clk);
            #1 meterDone = 1'b0;
         end
      end
   end

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [7:0] expCode(input int k);
      logic [2:0] f;
      logic [2:0] p;
      logic [1:0] d;
      f = 3'(6 + k / 8);
      p = 3'(6 + (k / 4) % 2);
      d = 2'(k % 4);
      return {f, p, d};
   endfunction

   function automatic logic [7:0] codes();
      return {ControlFrequency, ControlPeriodic, ControlDuty};
   endfunction

   task automatic startSweep(input logic cont);
      Continuous = cont;
      Start      = 1'b1;
      tick();
      Start      = 1'b0;
   endtask

   task automatic runSweep(input int budget, output int cycles, output int nMeas,
                           output int firstMeas, output int firstErr);
      cycles    = 0;
      nMeas     = 0;
      firstMeas = -1;
      firstErr  = -1;
      while (cycles < budget) begin
         tick();
         cycles++;
         if (MeasStart) begin
            if (firstMeas < 0) firstMeas = cycles;
            checkValue("meas_code", 32'(codes()), 32'(expCode(nMeas)));
            nMeas++;
         end
         if (ErrTimeout && firstErr < 0) firstErr = cycles;
         if (SweepDone) break;
      end
      checkValue("sweep_end_seen", 32'(SweepDone), 32'd1);
   endtask

   int cycles, nMeas, firstMeas, firstErr, nSweepDone;

   initial begin
      Rst_n      = 1'b0;
      Start      = 1'b0;
      Abort      = 1'b0;
      Continuous = 1'b0;
      manualDone = 1'b0;
      meterMode  = 1'b0;

      // Reset, then idle with Start low
      repeat (3) tick();
      checkValue("rst_codes", 32'(codes()), 32'd0);
      checkValue("rst_measstart", 32'(MeasStart), 32'd0);
      checkValue("rst_busy", 32'(Busy), 32'd0);
      checkValue("rst_sweepdone", 32'(SweepDone), 32'd0);
      checkValue("rst_stepindex", 32'(StepIndex), 32'd0);
      checkValue("rst_errtimeout", 32'(ErrTimeout), 32'd0);
      Rst_n = 1'b1;
      repeat (3) tick();
      checkValue("idle_busy", 32'(Busy), 32'd0);
      checkValue("idle_codes", 32'(codes()), 32'd0);

      // Full single sweep with a responsive meter: 7 cycles per step
      meterMode = 1'b1;
      startSweep(1'b0);
      checkValue("start_busy", 32'(Busy), 32'd1);
      checkValue("start_codes", 32'(codes()), 32'(8'b110_110_00));
      runSweep(400, cycles, nMeas, firstMeas, firstErr);
      checkValue("full_first_meas", 32'(firstMeas), 32'd4);
      checkValue("full_cycles", 32'(cycles), 32'd112);
      checkValue("full_nmeas", 32'(nMeas), 32'd16);
      checkValue("full_stepindex", 32'(StepIndex), 32'd16);
      checkValue("full_errtimeout", 32'(ErrTimeout), 32'd0);
      checkValue("full_last_codes", 32'(codes()), 32'(8'b111_111_11));
      checkValue("full_busy_end", 32'(Busy), 32'd0);
      tick();
      checkValue("full_done_pulse", 32'(SweepDone), 32'd0);
      checkValue("full_codes_held", 32'(codes()), 32'(8'b111_111_11));

      // Silent meter: every step times out, 4+16+1 cycles each
      meterMode = 1'b0;
      repeat (4) tick();
      startSweep(1'b0);
      runSweep(800, cycles, nMeas, firstMeas, firstErr);
      checkValue("to_cycles", 32'(cycles), 32'd336);
      checkValue("to_first_err", 32'(firstErr), 32'd20);
      checkValue("to_nmeas", 32'(nMeas), 32'd16);
      checkValue("to_errtimeout", 32'(ErrTimeout), 32'd1);
      checkValue("to_stepindex", 32'(StepIndex), 32'd16);

      // MeasDone exactly on the timeout cycle wins over the timeout
      tick();
      startSweep(1'b0);
      checkValue("edge_err_cleared", 32'(ErrTimeout), 32'd0);
      cycles = 0;
      while (!MeasStart && cycles < 20) begin
         tick();
         cycles++;
      end
      checkValue("edge_meas_latency", 32'(cycles), 32'd4);
      repeat (15) tick();
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      checkValue("edge_no_err", 32'(ErrTimeout), 32'd0);
      checkValue("edge_step_pending", 32'(StepIndex), 32'd0);
      tick();
      checkValue("edge_step_adv", 32'(StepIndex), 32'd1);
      checkValue("edge_codes_adv", 32'(codes()), 32'(8'b110_110_01));
      checkValue("edge_err_after", 32'(ErrTimeout), 32'd0);
      Abort = 1'b1;
      tick();
      Abort = 1'b0;
      checkValue("edge_abort_busy", 32'(Busy), 32'd0);
      checkValue("edge_abort_codes", 32'(codes()), 32'd0);
      checkValue("edge_abort_stepidx", 32'(StepIndex), 32'd1);

      // Continuous sweep wraps, then abort
      meterMode  = 1'b1;
      tick();
      startSweep(1'b1);
      nSweepDone = 0;
      nMeas      = 0;
      for (int i = 1; i <= 119; i++) begin
         tick();
         if (SweepDone) nSweepDone++;
         if (MeasStart) nMeas++;
         if (i == 111) begin
            checkValue("cont_last_idx", 32'(StepIndex), 32'd15);
            checkValue("cont_last_codes", 32'(codes()), 32'(8'b111_111_11));
         end
         if (i == 112) begin
            checkValue("cont_wrap_idx", 32'(StepIndex), 32'd0);
            checkValue("cont_wrap_codes", 32'(codes()), 32'(8'b110_110_00));
            checkValue("cont_wrap_busy", 32'(Busy), 32'd1);
            checkValue("cont_nmeas", 32'(nMeas), 32'd16);
         end
      end
      checkValue("cont_no_sweepdone", 32'(nSweepDone), 32'd0);
      checkValue("cont_second_idx", 32'(StepIndex), 32'd1);
      checkValue("cont_second_codes", 32'(codes()), 32'(8'b110_110_01));
      meterMode = 1'b0;
      Abort     = 1'b1;
      tick();
      Abort     = 1'b0;
      checkValue("cont_abort_busy", 32'(Busy), 32'd0);
      checkValue("cont_abort_codes", 32'(codes()), 32'd0);
      checkValue("cont_abort_meas", 32'(MeasStart), 32'd0);
      checkValue("cont_abort_idx", 32'(StepIndex), 32'd1);
      checkValue("cont_abort_nodone", 32'(SweepDone), 32'd0);

      // Start while busy and MeasDone during SETTLE are ignored; async reset mid-MEASURE
      meterMode = 1'b1;
      repeat (3) tick();
      startSweep(1'b0);
      repeat (2) tick();
      Start      = 1'b1;
      manualDone = 1'b1;
      tick();
      Start      = 1'b0;
      manualDone = 1'b0;
      tick();
      checkValue("ign_meas_tick4", 32'(MeasStart), 32'd1);
      repeat (2) tick();
      checkValue("ign_idx_tick6", 32'(StepIndex), 32'd0);
      tick();
      checkValue("ign_idx_tick7", 32'(StepIndex), 32'd1);
      repeat (4) tick();
      checkValue("ign_meas_tick11", 32'(MeasStart), 32'd1);
      tick();
      #2 Rst_n = 1'b0;
      #1;
      checkValue("arst_codes", 32'(codes()), 32'd0);
      checkValue("arst_busy", 32'(Busy), 32'd0);
      checkValue("arst_stepindex", 32'(StepIndex), 32'd0);
      checkValue("arst_measstart", 32'(MeasStart), 32'd0);
      meterMode = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (3) tick();
      checkValue("arst_stays_idle", 32'(Busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
